// File: rtl/nested_shift_tx_pkg.sv
// Shared types and constants for the nested_shift_tx parallel-to-serial transmitter.
package nested_shift_tx_pkg;

  // Transmitter states; PARITY is only reachable when the parity bit is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Level driven on the serial line between words.
  localparam logic IDLE_LEVEL_DEF = 1'b1;

  // Bit-counter width for a word of the given width (never narrower than one bit).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/nested_shift_tx_if.sv
// Load handshake and serial-side signals of nested_shift_tx, grouped into one bundle.
// master: the word producer / link observer. slave: the transmitter itself.
interface nested_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic             i_cg;
  logic             i_tick;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_txd;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_cg, i_tick, i_valid, i_data,
    input  o_ready, o_txd, o_busy, o_done
  );

  modport slave (
    input  i_cg, i_tick, i_valid, i_data,
    output o_ready, o_txd, o_busy, o_done
  );
endinterface

// File: rtl/nested_shift_tx_parity_calc.sv
// Even-parity generator for the loaded word of nested_shift_tx.
// Only built when NESTED_SHIFT_TX_PARITY_EN is defined.
`ifdef NESTED_SHIFT_TX_PARITY_EN
module nested_shift_tx_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  // XOR of all data bits: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign o_parity = even_parity(i_data);

endmodule
`endif

// File: rtl/nested_shift_tx.sv
// nested_shift_tx: MSB-first parallel-to-serial transmitter with a valid/ready load.
// Every state update is qualified by clock-gate (i_cg), then strobe/handshake
// (i_tick / load), then the FSM state. Async active-high reset (i_rst).
// Optional macro NESTED_SHIFT_TX_PARITY_EN appends one even-parity bit per word.
module nested_shift_tx
  import nested_shift_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  nested_shift_tx_if.slave   bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               txd_q;
  logic               busy_q;
  logic               done_q;
  logic               ready_s;
  logic               load_s;

`ifdef NESTED_SHIFT_TX_PARITY_EN
  logic               par_s;
  logic               par_q;

  nested_shift_tx_parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity (
    .i_data   (bus.i_data),
    .o_parity (par_s)
  );
`endif

  // Ready is combinational so a producer can be accepted in the same cycle it asks.
  assign ready_s = (state_q == ST_IDLE) && bus.i_cg && !i_rst;
  assign load_s  = bus.i_valid && ready_s;

  assign bus.o_ready = ready_s;
  assign bus.o_txd   = txd_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

  // Transmitter FSM: load on handshake, shift one bit per gated tick, pulse done at the end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      txd_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NESTED_SHIFT_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // done is a one-cycle pulse and must drop even while the clock gate is closed
      done_q <= 1'b0;
      if (bus.i_cg) begin
        case (state_q)
          ST_IDLE: begin
            // any i_tick in the load cycle is ignored: the first bit is driven by the load itself
            if (load_s) begin
              state_q <= ST_SHIFT;
              shreg_q <= bus.i_data;
              cnt_q   <= CNT_LAST;
              txd_q   <= bus.i_data[WIDTH-1];
              busy_q  <= 1'b1;
`ifdef NESTED_SHIFT_TX_PARITY_EN
              par_q   <= par_s;
`endif
            end
          end
          ST_SHIFT: begin
            if (bus.i_tick) begin
              if (cnt_q != CNT_ZERO) begin
                // shreg_q[WIDTH-1] is the bit on the line; the next one moves up into its place
                shreg_q <= shreg_q << 1'b1;
                txd_q   <= shreg_q[WIDTH-2];
                cnt_q   <= cnt_q - CNT_ONE;
              end else begin
`ifdef NESTED_SHIFT_TX_PARITY_EN
                state_q <= ST_PARITY;
                txd_q   <= par_q;
`else
                state_q <= ST_IDLE;
                txd_q   <= IDLE_LEVEL;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end
            end
          end
`ifdef NESTED_SHIFT_TX_PARITY_EN
          ST_PARITY: begin
            if (bus.i_tick) begin
              state_q <= ST_IDLE;
              txd_q   <= IDLE_LEVEL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`endif
          default: begin
            // unreachable encoding: fall back to a quiet idle line
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            txd_q   <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/nested_shift_tx.md
Name: nested_shift_tx

Overview:
- Parallel-to-serial transmitter, MSB first, with a valid/ready load interface.
- Drives one bit per qualified bit-strobe onto a single serial line.
- Transmit-side counterpart of the team's nested-enable capture registers: every state update sits under a three-level qualification (clock-gate, then strobe/handshake, then state condition).
- Sits between a word-producing datapath and a pin-level or bit-serial link.

Parameters:
- WIDTH, 8, data word width in bits; WIDTH >= 2.
- IDLE_LEVEL, 1'b1, value driven on o_txd when not transmitting.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_cg  input  1  clock-gate enable; when 0 all internal state holds.
- i_tick  input  1  bit strobe; advances one bit per qualified cycle.
- i_valid  input  1  load request.
- i_data  input  WIDTH  word to transmit; sampled on handshake.
- o_ready  output  1  load accepted this cycle when i_valid=1.
- o_txd  output  1  serial data, registered.
- o_busy  output  1  transmission in progress.
- o_done  output  1  single-cycle pulse when last bit completes.

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-high (i_rst). All flops are cleared asynchronously.
- Reset values:
  - state = IDLE; shift register = 0; bit counter = 0.
  - o_txd = IDLE_LEVEL; o_busy = 0; o_done = 0.
  - o_ready = 0 while i_rst is high.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- o_ready is combinational: (state==IDLE) && i_cg && !i_rst.
- Handshake:
  - Load occurs when i_cg && i_valid && o_ready.
  - The next cycle: state = SHIFT, shreg = i_data, cnt = WIDTH-1, o_txd = i_data[WIDTH-1], o_busy = 1.
  - Load-to-first-bit latency is 1 cycle.
  - i_tick in the load cycle is ignored.
  - i_valid while not ready is ignored; no queuing.
- In SHIFT, on i_cg && i_tick:
  - If cnt != 0: shift left by one, o_txd = next MSB, cnt -= 1.
  - If cnt == 0: go to IDLE (or PARITY), o_txd = IDLE_LEVEL (or parity bit).
- Each bit is held on o_txd from one qualified tick to the next. With a constant i_tick=1 and i_cg=1, a word occupies exactly WIDTH cycles.
- o_done:
  - Registered; 1 for exactly one cycle, the cycle after the final qualified tick (the entry to IDLE).
  - Cleared on the next edge regardless of i_cg.
- o_busy = (state != IDLE), registered alongside state.
- i_cg = 0:
  - Every flop except o_done holds, including mid-word; o_txd is frozen.
  - i_tick is ignored.
  - o_ready = 0.
- Back-to-back: a new load is possible in the cycle o_done is high (state is IDLE). There is no gap cycle beyond that one IDLE cycle.
- Reset mid-word: immediate return to the reset values; no o_done.
- Counter width is $clog2(WIDTH). cnt never wraps because it is reloaded on load.

Optional Feature:
- Macro: NESTED_SHIFT_TX_PARITY_EN.
- Defined:
  - After the last data bit, the state goes to PARITY and o_txd = even parity (XOR of the loaded word) for one qualified tick.
  - Then IDLE, with o_done asserted.
  - Word time becomes WIDTH+1 ticks.
  - The parity bit is computed at load and stored in a 1-bit flop.
- Undefined: the PARITY state, its flop and its logic are absent; SHIFT goes directly to IDLE.

Decomposition:
- Package nested_shift_tx_pkg:
  - state enum type (IDLE, SHIFT, PARITY).
  - localparam function for counter width.
  - IDLE_LEVEL default constant.
- No sub-module is needed. Optional sub-module: parity_calc (reduction XOR), instantiated only under the macro.

Test Plan:
- Reset: assert i_rst mid-sim -> o_txd=1, o_busy=0, o_ready=0 during reset; o_ready=1 one cycle after release with i_cg=1.
- Basic: WIDTH=8, i_tick=1 constant, load 8'hA5 -> o_txd sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after load; o_done high on cycle 9; o_busy high cycles 1..8.
- Sparse tick: i_tick every 4th cycle, load 8'h81 -> each bit held 4 cycles; total 32 cycles to o_done; ready stays 0 throughout.
- Gate stall: drop i_cg for 5 cycles after bit 3 of 8'h3C -> o_txd frozen at bit 3, ticks ignored; completion delayed by exactly 5 cycles; sequence intact.
- Back-to-back: i_valid held with 8'hFF then 8'h00 -> second load accepted in the o_done cycle; 16 data bits with one IDLE_LEVEL cycle between words.
- Parity (macro defined): load 8'h07 -> 8 data bits, then o_txd=1 for one tick, then o_done; load 8'h03 -> parity bit 0.
